// File: rtl/gumnut_int_ctrl.sv
// Multi-source interrupt controller for the Gumnut int_req/int_ack handshake.
// Maskable level/edge sources, fixed or round-robin arbitration, tracks one in-service source.
module gumnut_int_ctrl #(
    parameter int                 NUM_SRC   = 8,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = '0,
    parameter bit                 RR_EN     = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         irq_i,
    input  logic                       mask_we_i,
    input  logic [NUM_SRC-1:0]         mask_i,
    output logic [NUM_SRC-1:0]         mask_o,
    output logic [NUM_SRC-1:0]         pending_o,
    output logic                       int_req_o,
    input  logic                       int_ack_i,
    input  logic                       reti_i,
    output logic [$clog2(NUM_SRC)-1:0] int_id_o,
    output logic                       busy_o
);

    localparam int ID_W = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] irq_prev;
    logic [ID_W-1:0]    rr_ptr;

    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    winner;
    logic               found;
    logic               ack_hit;
    logic [NUM_SRC-1:0] edge_set;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] pending_nxt;

    assign mask_o    = mask;
    assign pending_o = pending;

    // Round-robin starts one past the last serviced source; fixed priority starts at 0.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        eligible = pending & mask;
        winner   = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int idx;
            if (RR_EN) begin
                idx = int'(rr_ptr) + 1 + k;
                if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            end else begin
                idx = k;
            end
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign ack_hit  = (state == REQ) && int_ack_i;
    assign edge_set = EDGE_MASK & irq_i & ~irq_prev;
    assign ack_clr  = ack_hit ? (EDGE_MASK & (NUM_SRC'(1) << int_id_o)) : '0;

    // A fresh edge in the ack cycle re-sets the flag after the clear.
    assign pending_nxt = (EDGE_MASK & ((pending & ~ack_clr) | edge_set))
                       | (~EDGE_MASK & irq_i);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            mask      <= '0;
            pending   <= '0;
            irq_prev  <= '0;
            rr_ptr    <= ID_W'(NUM_SRC - 1);
            int_req_o <= 1'b0;
            int_id_o  <= '0;
            busy_o    <= 1'b0;
        end else begin
            irq_prev <= irq_i;
            pending  <= pending_nxt;
            if (mask_we_i) mask <= mask_i;

            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= REQ;
                        int_id_o  <= winner;
                        int_req_o <= 1'b1;
                    end
                end
                REQ: begin
                    if (int_ack_i) begin
                        state     <= SERVICE;
                        int_req_o <= 1'b0;
                        busy_o    <= 1'b1;
                        rr_ptr    <= int_id_o;
                    end else if (!eligible[int_id_o]) begin
                        state     <= IDLE;
                        int_req_o <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (reti_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    int_req_o <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule
